fir_acc_mc: RTL and testbench
=============================

Name: fir_acc_mc

Overview:
- Multi-channel, parametrised accumulator for the FIR MAC datapath. It is the successor to the single-channel accumulator.
- Keeps one signed accumulator per channel and adds incoming products/sums with saturation.
- On the last tap of a sample, it commits a rounded, scaled and saturated result into a 2-entry output FIFO with a valid/ready handshake toward the output stage.

Parameters:
- IN_W, 21, width of signed input term acc_din
- ACC_W, 24, width of each signed per-channel accumulator (ACC_W >= IN_W)
- OUT_W, 16, width of signed output sample
- SHIFT, 5, arithmetic right shift applied at commit (0 allowed)
- N_CH, 2, number of independent channels (>=1)
- CH_W, $clog2(N_CH) min 1, channel index width

Ports:
- clk_b  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- acc_clr  in  1  clear all channel accumulators
- acc_en  in  1  accumulate acc_din into channel acc_ch this cycle
- acc_last  in  1  qualifies acc_en: this term is the last tap, commit result
- acc_ch  in  CH_W  target channel
- acc_din  in  IN_W  signed term to add
- out_valid  out  1  FIFO head holds a sample
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_W  signed sample at FIFO head
- out_ch  out  CH_W  channel of sample at head
- sat_flag  out  1  sticky: accumulator or output saturation occurred
- drop_flag  out  1  sticky: commit lost because FIFO full
- flag_clr  in  1  clears sat_flag and drop_flag

Behaviour:
- Reset: all accumulators 0, FIFO empty, out_valid 0, out_data 0, out_ch 0, sat_flag 0, drop_flag 0.
- Accumulate:
  - sum = acc[acc_ch] + sign-extended acc_din, computed at ACC_W+1 bits.
  - If sum exceeds the ACC_W signed range, clamp to max/min and set sat_flag.
  - Writes only channel acc_ch; other channels hold.
- Commit (acc_en && acc_last):
  - r = sum (saturated to ACC_W).
  - If SHIFT>0, add 2^(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Saturate to OUT_W; set sat_flag if clamped.
  - Push {r, acc_ch} to the FIFO.
  - acc[acc_ch] <= 0 in the same cycle, so the next sample starts clean.
- Latency: a commit at edge N makes the sample visible on out_data/out_valid from cycle N+1 if the FIFO was empty.
- acc_last without acc_en: ignored.
- acc_clr:
  - Zeroes all accumulators and has priority over acc_en in the same cycle.
  - No commit occurs that cycle and no push.
  - FIFO content and flags are unaffected.
- FIFO: depth 2, head on outputs.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle when full: allowed, no drop.
  - Push when full and no pop: sample discarded, drop_flag set, accumulator still cleared.
  - When empty, out_data/out_ch hold their last values and out_valid is 0.
- Flags:
  - sat_flag and drop_flag are sticky until flag_clr.
  - If flag_clr and a new set event coincide, set wins.
- Handshake: out_data/out_ch must stay stable while out_valid && !out_ready.
- Reset mid-operation: asserting rst_n low immediately returns everything to reset values; partial sums are lost.
- Channel index >= N_CH: the term is ignored, no state change.

Test Plan:
- Defaults, ch0: acc_en with din 100,200,300 (last on 300), out_ready=1 -> one cycle after the last edge: out_valid=1, out_data=(600+16)>>5=19, out_ch=0; acc[0] reads back 0 on the next accumulate.
- Interleave ch0 +1000 and ch1 -1000, four terms each, last on the 4th -> two samples: ch0 (4000+16)>>5=125, ch1 (-4000+16)>>>5=-125, in commit order.
- Positive overflow: ch0, 9 terms of 2^20-1 (exceeds 2^23-1) -> acc clamps to 8388607, output (8388607+16)>>5=262144 clamps to 32767, sat_flag=1 until flag_clr.
- Backpressure: out_ready=0, three single-term commits (din 32, 64, 96) -> FIFO holds 1 and 2 with out_data stable at 1, third dropped and drop_flag=1; raise out_ready -> 1 then 2 popped, then out_valid=0.
- Full FIFO with simultaneous pop+push -> no drop, drop_flag stays 0, order preserved.
- acc_clr with acc_en+acc_last in the same cycle -> no push, all accumulators 0; separately, rst_n pulse mid-accumulation -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fir_acc_mc.sv
// Multi-channel FIR accumulator: one saturating signed accumulator per channel.
// On the last tap it commits a rounded, scaled and saturated sample into a
// two-entry output FIFO with a valid/ready handshake. The FIFO head lives in
// dedicated registers so that out_data/out_ch hold their value while the FIFO is empty.
module fir_acc_mc #(
  parameter int IN_W  = 21,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 5,
  parameter int N_CH  = 2,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk_b,
  input  logic                    rst_n,
  input  logic                    acc_clr,
  input  logic                    acc_en,
  input  logic                    acc_last,
  input  logic [CH_W-1:0]         acc_ch,
  input  logic signed [IN_W-1:0]  acc_din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    sat_flag,
  output logic                    drop_flag,
  input  logic                    flag_clr
);

  // Wide enough to hold the rounded accumulator and the output limits with a guard bit.
  localparam int RW = (((ACC_W + 1) > OUT_W) ? (ACC_W + 1) : OUT_W) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [RW-1:0]    OMAX_W  = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0]    OMIN_W  = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OMAX_O  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN_O  = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_reg [N_CH];

  logic                    ch_ok;
  logic [CH_W-1:0]         rd_idx;
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W:0]   sum_wide;
  logic                    acc_ovf;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [RW-1:0]    r_ext;
  logic signed [RW-1:0]    rnd_ext;
  logic                    out_hi;
  logic                    out_lo;
  logic signed [OUT_W-1:0] res_data;

  logic                    term_ok;
  logic                    commit;
  logic                    pop;
  logic                    drop;
  logic                    sat_set;

  logic [1:0]              cnt_reg, cnt_next;
  logic signed [OUT_W-1:0] head_data_reg, head_data_next;
  logic [CH_W-1:0]         head_ch_reg, head_ch_next;
  logic signed [OUT_W-1:0] tail_data_reg, tail_data_next;
  logic [CH_W-1:0]         tail_ch_reg, tail_ch_next;
  logic                    sat_reg, drop_reg;

  // Out-of-range channels are ignored entirely; clear overrides any accumulate.
  assign ch_ok   = ({1'b0, acc_ch} < (CH_W+1)'(N_CH));
  assign term_ok = acc_en && ch_ok && !acc_clr;
  assign commit  = term_ok && acc_last;
  assign pop     = out_valid && out_ready;

  // Add the new term at one extra bit and clamp back to the accumulator range.
  always_comb begin
    rd_idx   = ch_ok ? acc_ch : '0;
    acc_cur  = acc_reg[rd_idx];
    sum_wide = {acc_cur[ACC_W-1], acc_cur} +
               {{(ACC_W+1-IN_W){acc_din[IN_W-1]}}, acc_din};
    acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (acc_ovf)
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      sum_sat = sum_wide[ACC_W-1:0];
    r_ext = {{(RW-ACC_W){sum_sat[ACC_W-1]}}, sum_sat};
  end

  // Round half up then arithmetic shift; a zero shift passes the value straight through.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] RND_K = RW'(1) <<< (SHIFT - 1);
      assign rnd_ext = (r_ext + RND_K) >>> SHIFT;
    end else begin : g_noround
      assign rnd_ext = r_ext;
    end
  endgenerate

  // Clamp the scaled value into the output sample range.
  always_comb begin
    out_hi = (rnd_ext > OMAX_W);
    out_lo = (rnd_ext < OMIN_W);
    if (out_hi)
      res_data = OMAX_O;
    else if (out_lo)
      res_data = OMIN_O;
    else
      res_data = rnd_ext[OUT_W-1:0];
  end

  // One register per channel; a commit restarts that channel from zero.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n)
          acc_reg[gi] <= '0;
        else if (acc_clr)
          acc_reg[gi] <= '0;
        else if (term_ok && (acc_ch == CH_W'(gi)))
          acc_reg[gi] <= acc_last ? '0 : sum_sat;
      end
    end
  endgenerate

  // Two-entry FIFO: head registers drive the outputs, tail holds the second sample.
  always_comb begin
    cnt_next       = cnt_reg;
    head_data_next = head_data_reg;
    head_ch_next   = head_ch_reg;
    tail_data_next = tail_data_reg;
    tail_ch_next   = tail_ch_reg;
    drop           = 1'b0;
    case (cnt_reg)
      2'd0: begin
        if (commit) begin
          head_data_next = res_data;
          head_ch_next   = acc_ch;
          cnt_next       = 2'd1;
        end
      end
      2'd1: begin
        if (pop && commit) begin
          head_data_next = res_data;
          head_ch_next   = acc_ch;
        end else if (pop) begin
          cnt_next = 2'd0;
        end else if (commit) begin
          tail_data_next = res_data;
          tail_ch_next   = acc_ch;
          cnt_next       = 2'd2;
        end
      end
      2'd2: begin
        if (pop) begin
          head_data_next = tail_data_reg;
          head_ch_next   = tail_ch_reg;
          if (commit) begin
            tail_data_next = res_data;
            tail_ch_next   = acc_ch;
          end else begin
            cnt_next = 2'd1;
          end
        end else if (commit) begin
          drop = 1'b1;
        end
      end
      default: cnt_next = 2'd0;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= 2'd0;
      head_data_reg <= '0;
      head_ch_reg   <= '0;
      tail_data_reg <= '0;
      tail_ch_reg   <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      head_data_reg <= head_data_next;
      head_ch_reg   <= head_ch_next;
      tail_data_reg <= tail_data_next;
      tail_ch_reg   <= tail_ch_next;
    end
  end

  assign sat_set = (term_ok && acc_ovf) || (commit && (out_hi || out_lo));

  // Sticky flags; a new event in the same cycle as flag_clr keeps the flag set.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      sat_reg  <= 1'b0;
      drop_reg <= 1'b0;
    end else begin
      sat_reg  <= sat_set | (sat_reg & ~flag_clr);
      drop_reg <= drop | (drop_reg & ~flag_clr);
    end
  end

  assign out_valid = (cnt_reg != 2'd0);
  assign out_data  = head_data_reg;
  assign out_ch    = head_ch_reg;
  assign sat_flag  = sat_reg;
  assign drop_flag = drop_reg;

endmodule

// File: tb/tb_fir_acc_mc.sv
// Scoreboard bench for fir_acc_mc: the stimulus pushes hand-computed samples,
// and a negedge monitor pops them on every accepted handshake.
module tb_fir_acc_mc;
  localparam int IN_W  = 21;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int SHIFT = 5;
  localparam int N_CH  = 2;
  localparam int CH_W  = 1;

  logic                    clk_b = 1'b0;
  logic                    rst_n;
  logic                    acc_clr, acc_en, acc_last;
  logic [CH_W-1:0]         acc_ch;
  logic signed [IN_W-1:0]  acc_din;
  logic                    out_valid, out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    sat_flag, drop_flag, flag_clr;

  typedef struct packed {
    logic signed [OUT_W-1:0] d;
    logic [CH_W-1:0]         ch;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic                    hold_pend = 1'b0;
  logic signed [OUT_W-1:0] hold_data;
  logic [CH_W-1:0]         hold_ch;

  fir_acc_mc #(
    .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .N_CH(N_CH), .CH_W(CH_W)
  ) dut (
    .clk_b(clk_b), .rst_n(rst_n), .acc_clr(acc_clr), .acc_en(acc_en),
    .acc_last(acc_last), .acc_ch(acc_ch), .acc_din(acc_din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .sat_flag(sat_flag), .drop_flag(drop_flag), .flag_clr(flag_clr)
  );

  always #5 clk_b = ~clk_b;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: compare every accepted sample and verify the head is stable under backpressure.
  always @(negedge clk_b) begin
    if (hold_pend && out_valid) begin
      checks++;
      if (out_data !== hold_data || out_ch !== hold_ch) begin
        errors++;
        $display("FAIL stable: got %0d/ch%0d expected %0d/ch%0d", out_data, out_ch, hold_data, hold_ch);
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL pop: got unexpected sample %0d/ch%0d expected none", out_data, out_ch);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_data !== e.d || out_ch !== e.ch) begin
          errors++;
          $display("FAIL pop: got %0d/ch%0d expected %0d/ch%0d", out_data, out_ch, e.d, e.ch);
        end else begin
          $display("pop  sample %0d ch%0d", out_data, out_ch);
        end
      end
    end
    hold_pend = out_valid && !out_ready;
    hold_data = out_data;
    hold_ch   = out_ch;
  end

  // Drive one term for one cycle; push the expected sample when it should reach the FIFO.
  task automatic term(input int ch, input int din, input bit last, input bit exp_push, input int exp_d);
    exp_t e;
    acc_en   = 1'b1;
    acc_ch   = CH_W'(ch);
    acc_din  = IN_W'(din);
    acc_last = last;
    if (exp_push) begin
      e.d  = OUT_W'(exp_d);
      e.ch = CH_W'(ch);
      sb_q.push_back(e);
    end
    @(posedge clk_b); #1;
    acc_en   = 1'b0;
    acc_last = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_b);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk_b);
      n++;
    end
    #1;
    chk({name, "_drained"}, sb_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; acc_clr = 1'b0; acc_en = 1'b0; acc_last = 1'b0;
    acc_ch = '0; acc_din = '0; out_ready = 1'b0; flag_clr = 1'b0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_drop", drop_flag, 0);
    repeat (2) @(posedge clk_b);
    #1 rst_n = 1'b1;
    cyc(1);

    // Basic accumulate on ch0: (600+16)>>5 = 19, visible one cycle after the commit edge
    out_ready = 1'b1;
    term(0, 100, 0, 0, 0);
    term(0, 200, 0, 0, 0);
    term(0, 300, 1, 1, 19);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 19);
    // Accumulator restarted: (64+16)>>5 = 2
    term(0, 64, 1, 1, 2);
    wait_drain("basic");

    // Interleaved channels: 125 on ch0 then -125 on ch1
    for (int i = 0; i < 4; i++) begin
      term(0, 1000, i == 3, i == 3, 125);
      term(1, -1000, i == 3, i == 3, -125);
    end
    wait_drain("interleave");

    // Positive overflow: clamps to 8388607, output clamps to 32767
    for (int i = 0; i < 9; i++)
      term(0, 1048575, i == 8, i == 8, 32767);
    chk("ovf_sat", sat_flag, 1);
    chk("ovf_drop", drop_flag, 0);
    flag_clr = 1'b1;
    cyc(1);
    flag_clr = 1'b0;
    chk("ovf_satclr", sat_flag, 0);
    wait_drain("ovf");

    // Backpressure: 1 and 2 stored, 3 dropped
    out_ready = 1'b0;
    term(0, 32, 1, 1, 1);
    term(0, 64, 1, 1, 2);
    term(1, 96, 1, 0, 3);
    chk("bp_drop", drop_flag, 1);
    chk("bp_head", out_data, 1);
    cyc(2);
    out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_empty", out_valid, 0);
    chk("bp_hold", out_data, 2);
    flag_clr = 1'b1;
    cyc(1);
    flag_clr = 1'b0;
    chk("bp_dropclr", drop_flag, 0);

    // Full FIFO with pop and push together: 4, 5, 6 in order, no drop
    out_ready = 1'b0;
    term(0, 128, 1, 1, 4);
    term(1, 160, 1, 1, 5);
    out_ready = 1'b1;
    term(0, 192, 1, 1, 6);
    chk("pp_drop", drop_flag, 0);
    wait_drain("pp");

    // acc_clr beats a simultaneous commit; accumulators restart from zero
    term(0, 500, 0, 0, 0);
    term(1, 700, 0, 0, 0);
    acc_clr = 1'b1;
    term(0, 10, 1, 0, 0);
    acc_clr = 1'b0;
    chk("clr_nopush", out_valid, 0);
    term(0, 32, 1, 1, 1);
    term(1, 32, 1, 1, 1);
    wait_drain("clr");

    // Asynchronous reset mid-operation loses FIFO content and partial sums
    out_ready = 1'b0;
    term(0, 200, 0, 0, 0);
    term(1, 320, 1, 0, 10);
    chk("pre_rst_data", out_data, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ch", out_ch, 0);
    @(posedge clk_b);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    term(0, 32, 1, 1, 1);
    wait_drain("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
